// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: micro-sequencer driving R2, data-mem strobes and T/X/VRF loads for VLOAD, VSTORE, VADD.
// Optional build macro VSEQ_WRAP_ERR_EN: abort on R2 wrap before the last lane and expose sticky err_o.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | waiting for start; op latched, lane counter cleared
//  SETUP     | load base address into R2 and/or X1/X2 operands
//  LD_RD     | VLOAD: issue read at R2 for lane k
//  LD_WAIT   | VLOAD: hold read for extra memory latency cycles
//  LD_CAP    | VLOAD: capture q into T[k], R2 <= R2+1
//  ST_WR     | VSTORE: write X1 lane k at R2, R2 <= R2+1
//  ADD_CALC  | VADD: load all T regs from the lane adders
//  WB        | write T0..T3 into the vector register file
//  DONE      | one-cycle completion pulse
module vec_mem_sequencer #(
    parameter int LANES   = 4,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              R2Ld_o,
    output logic              R2Sel_o,
    output logic              AddrSel_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [2:0]        MemIn_o,
    output logic              VoutSel_o,
    output logic [LANES-1:0]  TLd_o,
    output logic              X1Load_o,
    output logic              X2Load_o,
    output logic              VRFWrite_o
`ifdef VSEQ_WRAP_ERR_EN
   ,output logic              err_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_LD_RD, S_LD_WAIT, S_LD_CAP, S_ST_WR, S_ADD_CALC, S_WB, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_VLOAD  = 2'b00,
        OP_VSTORE = 2'b01,
        OP_VADD   = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

`ifdef VSEQ_WRAP_ERR_EN
    localparam logic WRAP_ERR_EN = 1'b1;
`else
    localparam logic WRAP_ERR_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [1:0] k_q, k_d;
    logic [1:0] wait_q, wait_d;
    logic       wrap_abort;

    logic             busy_q, done_q, r2ld_q, r2sel_q, addrsel_q, memrd_q, memwr_q;
    logic             voutsel_q, x1ld_q, x2ld_q, vrfwr_q;
    logic [2:0]       memin_q;
    logic [LANES-1:0] tld_q;

    logic             busy_d, done_d, r2ld_d, r2sel_d, addrsel_d, memrd_d, memwr_d;
    logic             voutsel_d, x1ld_d, x2ld_d, vrfwr_d;
    logic [2:0]       memin_d;
    logic [LANES-1:0] tld_d;

    // The lane at R2=all-ones is still serviced; only the lanes after it are dropped.
    assign wrap_abort = WRAP_ERR_EN && (addr_i == {ADDR_W{1'b1}}) && (k_q != 2'd3)
                        && ((state_q == S_LD_CAP) || (state_q == S_ST_WR));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = op_t'(op_i);
                    k_d     = 2'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                case (op_q)
                    OP_VLOAD:  state_d = S_LD_RD;
                    OP_VSTORE: state_d = S_ST_WR;
                    OP_VADD:   state_d = S_ADD_CALC;
                    default:   state_d = S_DONE;
                endcase
            end
            S_LD_RD: begin
                if (MEM_LAT > 1) begin
                    wait_d  = 2'(MEM_LAT - 2);
                    state_d = S_LD_WAIT;
                end else begin
                    state_d = S_LD_CAP;
                end
            end
            S_LD_WAIT: begin
                if (wait_q == 2'd0) state_d = S_LD_CAP;
                else                wait_d  = wait_q - 2'd1;
            end
            S_LD_CAP: begin
                if (wrap_abort)        state_d = S_DONE;
                else if (k_q == 2'd3)  state_d = S_WB;
                else begin
                    k_d     = k_q + 2'd1;
                    state_d = S_LD_RD;
                end
            end
            S_ST_WR: begin
                if (wrap_abort || (k_q == 2'd3)) state_d = S_DONE;
                else                             k_d     = k_q + 2'd1;
            end
            S_ADD_CALC: state_d = S_WB;
            S_WB:       state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they track state_q exactly.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = 1'b0;
        r2ld_d    = 1'b0;
        r2sel_d   = 1'b0;
        addrsel_d = 1'b1;
        memrd_d   = 1'b0;
        memwr_d   = 1'b0;
        memin_d   = 3'b100;
        voutsel_d = 1'b0;
        tld_d     = '0;
        x1ld_d    = 1'b0;
        x2ld_d    = 1'b0;
        vrfwr_d   = 1'b0;
        case (state_d)
            S_SETUP: begin
                case (op_d)
                    OP_VLOAD:  r2ld_d = 1'b1;
                    OP_VSTORE: begin
                        r2ld_d = 1'b1;
                        x1ld_d = 1'b1;
                    end
                    OP_VADD: begin
                        x1ld_d = 1'b1;
                        x2ld_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_LD_RD, S_LD_WAIT: begin
                addrsel_d = 1'b0;
                memrd_d   = 1'b1;
            end
            S_LD_CAP: begin
                voutsel_d  = 1'b1;
                tld_d[k_d] = 1'b1;
                r2ld_d     = 1'b1;
                r2sel_d    = 1'b1;
            end
            S_ST_WR: begin
                addrsel_d = 1'b0;
                memwr_d   = 1'b1;
                memin_d   = {1'b0, k_d};
                r2ld_d    = 1'b1;
                r2sel_d   = 1'b1;
            end
            S_ADD_CALC: tld_d   = '1;
            S_WB:       vrfwr_d = 1'b1;
            S_DONE:     done_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            op_q      <= OP_VLOAD;
            k_q       <= 2'd0;
            wait_q    <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r2ld_q    <= 1'b0;
            r2sel_q   <= 1'b0;
            addrsel_q <= 1'b1;
            memrd_q   <= 1'b0;
            memwr_q   <= 1'b0;
            memin_q   <= 3'b100;
            voutsel_q <= 1'b0;
            tld_q     <= '0;
            x1ld_q    <= 1'b0;
            x2ld_q    <= 1'b0;
            vrfwr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            k_q       <= k_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            r2ld_q    <= r2ld_d;
            r2sel_q   <= r2sel_d;
            addrsel_q <= addrsel_d;
            memrd_q   <= memrd_d;
            memwr_q   <= memwr_d;
            memin_q   <= memin_d;
            voutsel_q <= voutsel_d;
            tld_q     <= tld_d;
            x1ld_q    <= x1ld_d;
            x2ld_q    <= x2ld_d;
            vrfwr_q   <= vrfwr_d;
        end
    end

`ifdef VSEQ_WRAP_ERR_EN
    logic err_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            err_q <= 1'b0;
        end else if (wrap_abort || ((state_q == S_SETUP) && (op_q == OP_RSVD))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign R2Ld_o     = r2ld_q;
    assign R2Sel_o    = r2sel_q;
    assign AddrSel_o  = addrsel_q;
    assign MemRead_o  = memrd_q;
    assign MemWrite_o = memwr_q;
    assign MemIn_o    = memin_q;
    assign VoutSel_o  = voutsel_q;
    assign TLd_o      = tld_q;
    assign X1Load_o   = x1ld_q;
    assign X2Load_o   = x2ld_q;
    assign VRFWrite_o = vrfwr_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: drives vec_mem_sequencer against a small R2/memory/T/X/VRF datapath model.
// Honours VSEQ_WRAP_ERR_EN when the build defines it.
module tb_vec_mem_sequencer;

    logic        clock = 1'b0;
    logic        reset_n, start;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic        busy, done, R2Ld, R2Sel, AddrSel, MemRead, MemWrite, VoutSel, X1Load, X2Load, VRFWrite;
    logic [2:0]  MemIn;
    logic [3:0]  TLd;
`ifdef VSEQ_WRAP_ERR_EN
    logic        err;
`endif

    always #5 clock = ~clock;

    vec_mem_sequencer #(.LANES(4), .ADDR_W(8), .MEM_LAT(1)) dut (
        .clock_i(clock), .reset_n_i(reset_n), .start_i(start), .op_i(op), .addr_i(addr),
        .busy_o(busy), .done_o(done), .R2Ld_o(R2Ld), .R2Sel_o(R2Sel), .AddrSel_o(AddrSel),
        .MemRead_o(MemRead), .MemWrite_o(MemWrite), .MemIn_o(MemIn), .VoutSel_o(VoutSel),
        .TLd_o(TLd), .X1Load_o(X1Load), .X2Load_o(X2Load), .VRFWrite_o(VRFWrite)
`ifdef VSEQ_WRAP_ERR_EN
       ,.err_o(err)
`endif
    );

    logic [11:0] strobes;
    assign strobes = {R2Ld, R2Sel, MemRead, MemWrite, VoutSel, TLd, X1Load, X2Load, VRFWrite};

    // datapath model
    logic [7:0]  mem [256];
    logic [7:0]  q, r2;
    logic [7:0]  t [4];
    logic [31:0] x1, x2, vrf;
    logic [31:0] x1_src, x2_src;
    logic [7:0]  base_src;
    logic        init_req;

    assign addr = r2;

    function automatic logic [7:0] lane(input logic [31:0] v, input int i);
        return 8'(v >> (24 - 8 * i));
    endfunction

    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
            mem[8'h10] <= 8'h11;
            mem[8'h11] <= 8'h22;
            mem[8'h12] <= 8'h33;
            mem[8'h13] <= 8'h44;
            r2 <= 8'h00;
        end else begin
            if (MemWrite) mem[r2] <= lane(x1, int'(MemIn[1:0]));
            if (MemRead) q <= mem[r2];
            if (R2Ld) r2 <= R2Sel ? 8'(r2 + 8'd1) : base_src;
            if (X1Load) x1 <= x1_src;
            if (X2Load) x2 <= x2_src;
            for (int i = 0; i < 4; i++)
                if (TLd[i]) t[i] <= VoutSel ? q : 8'(lane(x1, i) + lane(x2, i));
            if (VRFWrite) vrf <= {t[0], t[1], t[2], t[3]};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // results of one run
    int          r_cyc, r_vrf_cyc, r_nvrf, r_nw, r_nrd;
    logic [15:0] r_tld;
    logic [31:0] r_waddr, r_wdata;
    logic [11:0] r_memin;
    bit          r_timeout;

    task automatic run_op(input logic [1:0] o, input logic [7:0] base,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op = o; base_src = base; x1_src = a; x2_src = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        r_cyc = 0; r_vrf_cyc = 0; r_nvrf = 0; r_nw = 0; r_nrd = 0;
        r_tld = '0; r_waddr = '0; r_wdata = '0; r_memin = '0; r_timeout = 1'b0;
        forever begin
            @(negedge clock);
            r_cyc++;
            if (|TLd) r_tld = {r_tld[11:0], TLd};
            if (MemRead) r_nrd++;
            if (MemWrite) begin
                r_nw++;
                r_waddr = {r_waddr[23:0], addr};
                r_wdata = {r_wdata[23:0], lane(x1, int'(MemIn[1:0]))};
                r_memin = {r_memin[8:0], MemIn};
            end
            if (VRFWrite) begin
                r_vrf_cyc = r_cyc;
                r_nvrf++;
            end
            if (done) break;
            if (r_cyc > 60) begin
                r_timeout = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  base;
        logic [31:0] x1;
        logic [31:0] x2;
        int          cyc;
        int          vrf_cyc;
        logic [31:0] vrf;
        logic [15:0] tld;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [11:0] memin;
        int          nw;
        int          nrd;
        bit          err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        bit seen;
        int vcount;
        logic [11:0] str_or;

        //           op     base   x1            x2            cyc vrfc vrf           tld       waddr         wdata         memin   nw nrd err
        vecs[0] = '{2'b00, 8'h10, 32'h0,        32'h0,        11, 10, 32'h11223344, 16'h1248, 32'h0,        32'h0,        12'h0,   0, 4, 1'b0};
        vecs[1] = '{2'b01, 8'h20, 32'hA1B2C3D4, 32'h0,         6,  0, 32'h0,        16'h0,    32'h20212223, 32'hA1B2C3D4, 12'h053, 4, 0, 1'b0};
        vecs[2] = '{2'b10, 8'h00, 32'h01020304, 32'hFF010101,  4,  3, 32'h00030405, 16'h000F, 32'h0,        32'h0,        12'h0,   0, 0, 1'b0};
`ifdef VSEQ_WRAP_ERR_EN
        vecs[3] = '{2'b00, 8'hFD, 32'h0,        32'h0,         8,  0, 32'h0,        16'h0124, 32'h0,        32'h0,        12'h0,   0, 3, 1'b1};
        vecs[4] = '{2'b01, 8'hFE, 32'h11223344, 32'h0,         4,  0, 32'h0,        16'h0,    32'h0000FEFF, 32'h00001122, 12'h001, 2, 0, 1'b1};
`else
        vecs[3] = '{2'b00, 8'hFD, 32'h0,        32'h0,        11, 10, 32'hFEFF0001, 16'h1248, 32'h0,        32'h0,        12'h0,   0, 4, 1'b0};
        vecs[4] = '{2'b01, 8'hFE, 32'h11223344, 32'h0,         6,  0, 32'h0,        16'h0,    32'hFEFF0001, 32'h11223344, 12'h053, 4, 0, 1'b0};
`endif
        vecs[5] = '{2'b00, 8'h20, 32'h0,        32'h0,        11, 10, 32'hA1B2C3D4, 16'h1248, 32'h0,        32'h0,        12'h0,   0, 4, 1'b0};
`ifdef VSEQ_WRAP_ERR_EN
        vecs[6] = '{2'b11, 8'h00, 32'h0,        32'h0,         2,  0, 32'h0,        16'h0,    32'h0,        32'h0,        12'h0,   0, 0, 1'b1};
`else
        vecs[6] = '{2'b11, 8'h00, 32'h0,        32'h0,         2,  0, 32'h0,        16'h0,    32'h0,        32'h0,        12'h0,   0, 0, 1'b0};
`endif

        reset_n = 1'b0; start = 1'b0; op = 2'b00;
        base_src = 8'h00; x1_src = '0; x2_src = '0; init_req = 1'b1;
        repeat (3) @(negedge clock);
        init_req = 1'b0;

        chk("reset_busy",    32'(busy), 32'h0);
        chk("reset_done",    32'(done), 32'h0);
        chk("reset_strobes", 32'(strobes), 32'h0);
        chk("reset_memin",   32'(MemIn), 32'h4);
        chk("reset_addrsel", 32'(AddrSel), 32'h1);
`ifdef VSEQ_WRAP_ERR_EN
        chk("reset_err", 32'(err), 32'h0);
`endif
        reset_n = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].op, vecs[v].base, vecs[v].x1, vecs[v].x2);
            chk($sformatf("v%0d_timeout", v), 32'(r_timeout), 32'h0);
            chk($sformatf("v%0d_cycles", v), 32'(r_cyc), 32'(vecs[v].cyc));
            chk($sformatf("v%0d_vrf_cycle", v), 32'(r_vrf_cyc), 32'(vecs[v].vrf_cyc));
            chk($sformatf("v%0d_vrf_count", v), 32'(r_nvrf), (vecs[v].vrf_cyc != 0) ? 32'h1 : 32'h0);
            if (vecs[v].vrf_cyc != 0) chk($sformatf("v%0d_vrf", v), vrf, vecs[v].vrf);
            chk($sformatf("v%0d_tld_seq", v), 32'(r_tld), 32'(vecs[v].tld));
            chk($sformatf("v%0d_waddr_seq", v), r_waddr, vecs[v].waddr);
            chk($sformatf("v%0d_wdata_seq", v), r_wdata, vecs[v].wdata);
            chk($sformatf("v%0d_memin_seq", v), 32'(r_memin), 32'(vecs[v].memin));
            chk($sformatf("v%0d_nwrites", v), 32'(r_nw), 32'(vecs[v].nw));
            chk($sformatf("v%0d_nreads", v), 32'(r_nrd), 32'(vecs[v].nrd));
`ifdef VSEQ_WRAP_ERR_EN
            chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].err));
`endif
            @(negedge clock);
            chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'h0);
            chk($sformatf("v%0d_idle_strobes", v), {20'h0, strobes}, 32'h0);
        end

        // reset during VLOAD lane 2
        @(negedge clock);
        op = 2'b00; base_src = 8'h10; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clock);
            n++;
            if (TLd[1]) seen = 1'b1;
        end
        chk("rst_reached_lane1", 32'(seen), 32'h1);
        @(negedge clock);
        chk("rst_lane2_read", 32'(MemRead), 32'h1);
        chk("rst_lane2_addr", 32'(addr), 32'h12);
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", 32'(strobes), 32'h0);
        chk("rst_memin", 32'(MemIn), 32'h4);
        vcount = 0;
        repeat (3) begin
            @(negedge clock);
            if (VRFWrite || busy) vcount++;
        end
        chk("rst_quiet", 32'(vcount), 32'h0);
        reset_n = 1'b1;
        run_op(2'b10, 8'h00, 32'h10203040, 32'h01010101);
        chk("rst_after_cycles", 32'(r_cyc), 32'd4);
        chk("rst_after_vrf", vrf, 32'h11213141);

        // start held high across done, op 11 twice
        @(negedge clock);
        @(negedge clock);
        op = 2'b11; start = 1'b1;
        n = 0; str_or = '0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            str_or = str_or | strobes;
            if (done) break;
        end
        chk("b2b_first_done_cycle", 32'(n), 32'd2);
        chk("b2b_no_strobes", 32'(str_or), 32'h0);
`ifdef VSEQ_WRAP_ERR_EN
        chk("b2b_err", 32'(err), 32'h1);
`endif
        @(negedge clock);
        chk("b2b_idle_gap", 32'(busy), 32'h0);
        @(negedge clock);
        chk("b2b_second_busy", 32'(busy), 32'h1);
        start = 1'b0;
        @(negedge clock);
        chk("b2b_second_done", 32'(done), 32'h1);
        @(negedge clock);
        chk("b2b_end_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
